branch_target_predictor_m: RTL and testbench
============================================

# branch_target_predictor_m

Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry. Each cycle it looks up the fetch PC and returns a taken/not-taken prediction and a predicted target. The Execute stage writes back each resolved branch to train the counters and allocate entries. `BranchPredicted` and the predicted target feed the PC source select logic; the Execute-side inputs close the loop from the branch resolution path.

## Interface
- `INDEX_BITS`, 4, BTB index width (2^INDEX_BITS entries); index = PC[INDEX_BITS+1:2]
- `CNT_W`, 16, width of the statistics counters
- `clk` in 1, single clock; all state updates on rising edge
- `reset` in 1, synchronous, active-high
- `PCF` in 32, fetch-stage PC (word aligned; PC[1:0] ignored)
- `BranchPredicted` out 1, predict taken for the instruction at `PCF` (combinational)
- `PredictedTargetF` out 32, BTA for `PCF` when `BranchPredicted`=1; 0 otherwise
- `BranchE` in 1, a valid (unflushed) branch is in Execute this cycle
- `PCE` in 32, PC of the Execute-stage branch
- `BranchTakenE` in 1, resolved direction of the Execute branch
- `BTAE` in 32, resolved branch target of the Execute branch
- `BranchPredictedE` in 1, prediction that was made for this branch at fetch
- `BranchCount` out CNT_W, resolved branches since reset (saturating)
- `MispredictCount` out CNT_W, mispredicted branches since reset (saturating)

## Operation
- Entry fields: `valid` (1), `tag` (30-INDEX_BITS = PC[31:INDEX_BITS+2]), `target` (32), `ctr` (2).
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; predict taken iff ctr[1]=1.
- Lookup (combinational from registered state): hitF = valid[idxF] & (tag[idxF]==tagF). `BranchPredicted` = hitF & ctr[idxF][1]. `PredictedTargetF` = `BranchPredicted` ? target[idxF] : 32'h0.
- Update, only when `BranchE`=1, at the end of the cycle:
  - Hit, taken: ctr saturating-increments (11 stays 11); target <= `BTAE`.
  - Hit, not taken: ctr saturating-decrements (00 stays 00); target unchanged.
  - Miss, taken: allocate. valid<=1, tag<=tagE, target<=`BTAE`, ctr<=10. This overwrites any conflicting entry.
  - Miss, not taken: no state change.
- `BranchE`=0: BTB unchanged regardless of other E inputs.
- Statistics, when `BranchE`=1:
  - `BranchCount` += 1.
  - `MispredictCount` += 1 if `BranchPredictedE` != `BranchTakenE`.
  - Both hold at all-ones (no wrap).
- Reset: all valid<=0, all ctr<=01, targets/tags<=0, both counters<=0.
- Outputs after reset: `BranchPredicted`=0, `PredictedTargetF`=0, `BranchCount`=0, `MispredictCount`=0.

## Timing
- Prediction latency 0: outputs reflect `PCF` in the same cycle and depend only on state and `PCF`.
- Update latency 1: an update in cycle N is visible to a lookup in cycle N+1.
- Same-cycle read/write to the same index: the lookup returns pre-update contents. There is no bypass.
- Only one update per cycle. Updates never stall, and the block has no backpressure.
- `reset` asserted concurrently with `BranchE`: reset wins and the update is discarded.
- Reset mid-stream clears all history in one cycle. Predictions are 0 from the following cycle.
- Aliasing: two PCs with the same index and different tags evict each other. A tag mismatch always predicts not taken.

## Test plan
- **Reset:** assert `reset` 1 cycle, then sweep `PCF` over 0x00..0x3C → `BranchPredicted`=0 and `PredictedTargetF`=0 for all; both counters 0.
- **Allocate:** `BranchE`=1, `PCE`=0x40, `BranchTakenE`=1, `BTAE`=0x100, `BranchPredictedE`=0 → next cycle `PCF`=0x40 gives `BranchPredicted`=1 and target 0x100; `BranchCount`=1, `MispredictCount`=1.
- **Hysteresis:** from ctr=10 at 0x40, two not-taken updates → after the first, prediction 0 (ctr 01); after the second, ctr 00. One taken update → ctr 01, still predicts 0. A second taken update → predicts 1.
- **Saturation:** five taken updates at 0x40 → ctr 11; one not-taken → still predicts taken.
- **Aliasing and no-allocate:**
  - With 16 entries, allocate 0x40 (taken, BTA 0x100), then allocate 0x80 (taken, BTA 0x200) → `PCF`=0x40 predicts 0; `PCF`=0x80 predicts 0x200.
  - A not-taken miss at 0xC0 leaves 0x80 intact.
- **Same-cycle and reset collision:**
  - `PCF`=`PCE`=0x40 during an allocating update → `BranchPredicted`=0 that cycle, 1 the next.
  - Assert `reset` together with `BranchE`=1 → no allocation; counters 0.
  - Force `BranchCount` to all-ones via 2^CNT_W branches (or CNT_W=4 build) → holds at 0xF.

Source files
------------

// File: rtl/branch_target_predictor_m_if.sv
// Fetch/Execute bus of the branch target predictor.
//   master : driven by the pipeline (fetch PC, resolved-branch writeback),
//            observes prediction and statistics.
//   slave  : the predictor itself.
// Ports:
//   PCF              fetch PC to look up
//   BranchPredicted  predict taken for PCF
//   PredictedTargetF predicted target for PCF (0 when not predicted taken)
//   BranchE          valid branch resolving in Execute
//   PCE              PC of the Execute branch
//   BranchTakenE     resolved direction
//   BTAE             resolved target
//   BranchPredictedE prediction that fetch made for this branch
//   BranchCount      resolved branches since reset (saturating)
//   MispredictCount  mispredicted branches since reset (saturating)
interface branch_target_predictor_m_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      PCF;
    logic             BranchPredicted;
    logic [31:0]      PredictedTargetF;
    logic             BranchE;
    logic [31:0]      PCE;
    logic             BranchTakenE;
    logic [31:0]      BTAE;
    logic             BranchPredictedE;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] MispredictCount;

    modport master (
        output PCF, BranchE, PCE, BranchTakenE, BTAE, BranchPredictedE,
        input  BranchPredicted, PredictedTargetF, BranchCount, MispredictCount
    );

    modport slave (
        input  PCF, BranchE, PCE, BranchTakenE, BTAE, BranchPredictedE,
        output BranchPredicted, PredictedTargetF, BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_target_predictor_m.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry. Fetch lookup is purely combinational from registered state; the
// Execute stage trains/allocates entries one cycle later.
// Ports:
//   clk    single clock, all state on rising edge
//   reset  synchronous, active-high; wins over a concurrent update
//   bus    predictor side of the fetch/execute bus (see interface header)
module branch_target_predictor_m #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    branch_target_predictor_m_if.slave    bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    // BTB state
    logic [ENTRIES-1:0]             valid_q,  valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q,    tag_d;
    logic [ENTRIES-1:0][31:0]       target_q, target_d;
    logic [ENTRIES-1:0][1:0]        ctr_q,    ctr_d;

    // Statistics
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]      tag_f, tag_e;
    logic                  hit_f, hit_e, pred_f;

    // PC[1:0] carries no information for word-aligned fetch
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.PCF[1:0], bus.PCE[1:0]};

    assign idx_f = bus.PCF[INDEX_BITS+1:2];
    assign tag_f = bus.PCF[31:INDEX_BITS+2];
    assign idx_e = bus.PCE[INDEX_BITS+1:2];
    assign tag_e = bus.PCE[31:INDEX_BITS+2];

    // Lookup reads registered state only, so a same-cycle update to the
    // same index is seen by fetch one cycle later (no bypass).
    assign hit_f  = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_f = hit_f && ctr_q[idx_f][1];
    assign hit_e  = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign bus.BranchPredicted  = pred_f;
    assign bus.PredictedTargetF = pred_f ? target_q[idx_f] : 32'h0;
    assign bus.BranchCount      = bcnt_q;
    assign bus.MispredictCount  = mcnt_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        bcnt_d   = bcnt_q;
        mcnt_d   = mcnt_q;

        if (bus.BranchE) begin
            if (hit_e) begin
                if (bus.BranchTakenE) begin
                    if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
                    target_d[idx_e] = bus.BTAE;
                end else if (ctr_q[idx_e] != 2'b00) begin
                    ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
                end
            end else if (bus.BranchTakenE) begin
                // Allocate weak-taken, evicting whatever aliased here
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = bus.BTAE;
                ctr_d[idx_e]    = 2'b10;
            end
            // Not-taken miss: nothing worth remembering

            if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
            if ((bus.BranchPredictedE != bus.BranchTakenE) && (mcnt_q != '1))
                mcnt_d = mcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{2'b01}};  // weak not-taken
            bcnt_q   <= '0;
            mcnt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            bcnt_q   <= bcnt_d;
            mcnt_q   <= mcnt_d;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor_m.sv
// Self-checking bench for branch_target_predictor_m. Built with CNT_W=4 so
// statistics saturation is reachable in a few cycles.
module tb_branch_target_predictor_m;
    localparam int INDEX_BITS = 4;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic reset;

    int tests  = 0;
    int failed = 0;

    // Expected statistics, tracked independently of the DUT
    logic [CNT_W-1:0] exp_bc, exp_mc;

    // Scoreboards: expectations pushed at stimulus, popped at sampling
    logic [32:0]        lk_q[$];
    logic [2*CNT_W-1:0] cnt_q[$];
    logic [32:0]        lk_e, lk_o;
    logic [2*CNT_W-1:0] cnt_e, cnt_o;

    branch_target_predictor_m_if #(.CNT_W(CNT_W)) bus();

    branch_target_predictor_m #(.INDEX_BITS(INDEX_BITS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_e();
        bus.BranchE          = 1'b0;
        bus.PCE              = 32'h0;
        bus.BranchTakenE     = 1'b0;
        bus.BTAE             = 32'h0;
        bus.BranchPredictedE = 1'b0;
    endtask

    task automatic model_count(input logic tk, input logic pe);
        if (exp_bc != '1) exp_bc = exp_bc + 1'b1;
        if (tk != pe && exp_mc != '1) exp_mc = exp_mc + 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_bc = '0;
        exp_mc = '0;
    endtask

    // One resolved branch, committed at the next rising edge
    task automatic upd(input logic [31:0] pce, input logic tk,
                       input logic [31:0] bta, input logic pe);
        bus.BranchE          = 1'b1;
        bus.PCE              = pce;
        bus.BranchTakenE     = tk;
        bus.BTAE             = bta;
        bus.BranchPredictedE = pe;
        tick();
        idle_e();
        model_count(tk, pe);
    endtask

    // Drive a fetch PC, queue the expectation, sample after settling
    task automatic probe(input logic [31:0] pc, input logic ep, input logic [31:0] et);
        bus.PCF = pc;
        lk_q.push_back({ep, et});
        #1;
        lk_o = {bus.BranchPredicted, bus.PredictedTargetF};
        lk_e = lk_q.pop_front();
    endtask

    task automatic cprobe();
        cnt_q.push_back({exp_bc, exp_mc});
        cnt_o = {bus.BranchCount, bus.MispredictCount};
        cnt_e = cnt_q.pop_front();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            probe(32'(i * 4), 1'b0, 32'h0);
            tests++;
            if (lk_o !== lk_e) begin
                failed++;
                $display("FAIL reset_lookup pc=%h got=%h want=%h", i * 4, lk_o, lk_e);
            end
            tick();
        end
        cprobe();
        tests++;
        if (cnt_o !== cnt_e) begin
            failed++;
            $display("FAIL reset_counts got=%h want=%h", cnt_o, cnt_e);
        end
    endtask

    task automatic test_allocate();
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        probe(32'h40, 1'b1, 32'h100);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL alloc_lookup got=%h want=%h", lk_o, lk_e);
        end
        cprobe();
        tests++;
        if (cnt_o !== cnt_e || cnt_e !== {4'd1, 4'd1}) begin
            failed++;
            $display("FAIL alloc_counts got=%h want=%h", cnt_o, cnt_e);
        end
    endtask

    task automatic test_hysteresis();
        // ctr starts at 10: NT -> 01, NT -> 00, T -> 01, T -> 10
        logic       tk_t[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       pe_t[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       ep_t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            upd(32'h40, tk_t[i], 32'h100, pe_t[i]);
            probe(32'h40, ep_t[i], ep_t[i] ? 32'h100 : 32'h0);
            tests++;
            if (lk_o !== lk_e) begin
                failed++;
                $display("FAIL hysteresis step=%0d got=%h want=%h", i, lk_o, lk_e);
            end
        end
        cprobe();
        tests++;
        if (cnt_o !== cnt_e) begin
            failed++;
            $display("FAIL hysteresis_counts got=%h want=%h", cnt_o, cnt_e);
        end
    endtask

    task automatic test_saturation();
        // From 10, five taken hits with moving targets: must stay taken
        for (int i = 0; i < 5; i++) begin
            upd(32'h40, 1'b1, 32'h100 + 32'(i * 16), 1'b1);
            probe(32'h40, 1'b1, 32'h100 + 32'(i * 16));
            tests++;
            if (lk_o !== lk_e) begin
                failed++;
                $display("FAIL saturation_taken step=%0d got=%h want=%h", i, lk_o, lk_e);
            end
        end
        // 11 -> 10 still taken, target unchanged by a not-taken hit
        upd(32'h40, 1'b0, 32'h999, 1'b1);
        probe(32'h40, 1'b1, 32'h140);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL saturation_nt1 got=%h want=%h", lk_o, lk_e);
        end
        // 10 -> 01 not taken
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        probe(32'h40, 1'b0, 32'h0);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL saturation_nt2 got=%h want=%h", lk_o, lk_e);
        end
        cprobe();
        tests++;
        if (cnt_o !== cnt_e) begin
            failed++;
            $display("FAIL saturation_counts got=%h want=%h", cnt_o, cnt_e);
        end
    endtask

    task automatic test_alias();
        do_reset();
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h80, 1'b1, 32'h200, 1'b0);
        probe(32'h40, 1'b0, 32'h0);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL alias_evicted got=%h want=%h", lk_o, lk_e);
        end
        probe(32'h80, 1'b1, 32'h200);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL alias_new got=%h want=%h", lk_o, lk_e);
        end
        // Not-taken miss on the same index must not disturb 0x80
        upd(32'hC0, 1'b0, 32'h300, 1'b0);
        probe(32'h80, 1'b1, 32'h200);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL no_alloc_keep got=%h want=%h", lk_o, lk_e);
        end
        probe(32'hC0, 1'b0, 32'h0);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL no_alloc_miss got=%h want=%h", lk_o, lk_e);
        end
        // BranchE low: other E inputs ignored
        bus.PCE = 32'h44; bus.BranchTakenE = 1'b1; bus.BTAE = 32'h400; bus.BranchPredictedE = 1'b1;
        tick();
        idle_e();
        probe(32'h44, 1'b0, 32'h0);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL idle_no_update got=%h want=%h", lk_o, lk_e);
        end
        cprobe();
        tests++;
        if (cnt_o !== cnt_e) begin
            failed++;
            $display("FAIL alias_counts got=%h want=%h", cnt_o, cnt_e);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus.BranchE = 1'b1; bus.PCE = 32'h40; bus.BranchTakenE = 1'b1;
        bus.BTAE = 32'h100; bus.BranchPredictedE = 1'b0;
        probe(32'h40, 1'b0, 32'h0);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL same_cycle_pre got=%h want=%h", lk_o, lk_e);
        end
        tick();
        idle_e();
        model_count(1'b1, 1'b0);
        probe(32'h40, 1'b1, 32'h100);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL same_cycle_post got=%h want=%h", lk_o, lk_e);
        end
    endtask

    task automatic test_reset_collision();
        // 0x40 is live from the previous test; reset must also wipe it
        bus.BranchE = 1'b1; bus.PCE = 32'h48; bus.BranchTakenE = 1'b1;
        bus.BTAE = 32'h300; bus.BranchPredictedE = 1'b0;
        do_reset();
        idle_e();
        probe(32'h48, 1'b0, 32'h0);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL reset_collision_alloc got=%h want=%h", lk_o, lk_e);
        end
        probe(32'h40, 1'b0, 32'h0);
        tests++;
        if (lk_o !== lk_e) begin
            failed++;
            $display("FAIL reset_clears_history got=%h want=%h", lk_o, lk_e);
        end
        cprobe();
        tests++;
        if (cnt_o !== cnt_e || cnt_e !== '0) begin
            failed++;
            $display("FAIL reset_collision_counts got=%h want=%h", cnt_o, cnt_e);
        end
    endtask

    task automatic test_count_saturation();
        do_reset();
        // Not-taken misses with a taken prediction: count both, touch no entry
        for (int i = 0; i < 14; i++) upd(32'hC4, 1'b0, 32'h0, 1'b1);
        cprobe();
        tests++;
        if (cnt_o !== cnt_e || cnt_e !== {4'hE, 4'hE}) begin
            failed++;
            $display("FAIL count_pre_sat got=%h want=%h", cnt_o, cnt_e);
        end
        for (int i = 0; i < 4; i++) upd(32'hC4, 1'b0, 32'h0, 1'b1);
        cprobe();
        tests++;
        if (cnt_o !== cnt_e || cnt_e !== {4'hF, 4'hF}) begin
            failed++;
            $display("FAIL count_saturated got=%h want=%h", cnt_o, cnt_e);
        end
    endtask

    initial begin
        reset   = 1'b1;
        bus.PCF = 32'h0;
        idle_e();
        exp_bc  = '0;
        exp_mc  = '0;
        tick();

        test_reset();
        test_allocate();
        test_hysteresis();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_reset_collision();
        test_count_saturation();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
